// File: rtl/search_frontend_pkg.sv
// search_frontend shared definitions.
// Frame geometry and FSM encoding for the searcher feeder.
package search_frontend_pkg;

    typedef enum logic [1:0] {
        LOAD,
        START,
        SEARCH,
        RESULT
    } feState_e;

    localparam int FRAME_WORDS = 19;
    localparam int TARGET_LSB  = 0;
    localparam int TARGET_W    = 5;
    localparam int MSG_BASE    = 3;
    localparam int MSG_WORDS   = FRAME_WORDS - MSG_BASE;
    localparam int IDX_W       = $clog2(FRAME_WORDS);
    localparam int SLOT_W      = $clog2(MSG_WORDS);

endpackage

// File: rtl/search_frontend_if.sv
// search_frontend host-side streams.
// Command words in, result records out, both valid/ready.
interface search_frontend_if #(
    parameter int CYCLE_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic [31:0]        out_digests;
    logic [CYCLE_W-1:0] out_cycles;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_digests,
        input  out_cycles
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_digests,
        output out_cycles
    );

endinterface

// File: rtl/search_frontend.sv
// search_frontend: assembles a 19-word command frame, runs one
// search on CollisionSearcher and returns the captured result.
module search_frontend
    import search_frontend_pkg::*;
#(
    parameter int CYCLE_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    search_frontend_if.slave     host,
    output logic                 s_start,
    output logic [TARGET_W-1:0]  s_target,
    output logic [511:0]         s_message,
    output logic [31:0]          s_counter,
    output logic [31:0]          s_increment,
    input  logic                 s_done,
    input  logic [31:0]          s_result,
    input  logic [31:0]          s_digests,
    output logic                 busy
);

    feState_e                  state;
    logic [IDX_W-1:0]          idx;
    logic [SLOT_W-1:0]         slot;
    logic [MSG_WORDS-1:0][31:0] msg;
    logic [CYCLE_W-1:0]        cycles;
    logic                      inReady;
    logic                      outValid;
    logic [31:0]               outResult;
    logic [31:0]               outDigests;
    logic [CYCLE_W-1:0]        outCycles;
    logic                      accept;
    logic                      lastWord;

    // Word 3 lands in the top slot, word 18 in slot 0.
    assign slot     = SLOT_W'(IDX_W'(FRAME_WORDS - 1) - idx);
    assign accept   = host.in_valid && inReady;
    assign lastWord = (idx == IDX_W'(FRAME_WORDS - 1));

    assign s_message        = msg;
    assign host.in_ready    = inReady;
    assign host.out_valid   = outValid;
    assign host.out_result  = outResult;
    assign host.out_digests = outDigests;
    assign host.out_cycles  = outCycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            idx         <= '0;
            msg         <= '0;
            cycles      <= '0;
            inReady     <= 1'b1;
            outValid    <= 1'b0;
            outResult   <= '0;
            outDigests  <= '0;
            outCycles   <= '0;
            s_start     <= 1'b0;
            s_target    <= '0;
            s_counter   <= '0;
            s_increment <= '0;
            busy        <= 1'b0;
        end else begin
            s_start <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        case (idx)
                            IDX_W'(0): s_target <= host.in_data[TARGET_LSB +: TARGET_W];
                            IDX_W'(1): s_counter <= host.in_data;
                            IDX_W'(2): s_increment <= host.in_data;
                            default:   msg[slot] <= host.in_data;
                        endcase
                        if (lastWord) begin
                            idx     <= '0;
                            state   <= START;
                            inReady <= 1'b0;
                            s_start <= 1'b1;
                            busy    <= 1'b1;
                            cycles  <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                START: begin
                    state  <= SEARCH;
                    cycles <= cycles + 1'b1;
                end
                SEARCH: begin
                    if (s_done) begin
                        outResult  <= s_result;
                        outDigests <= s_digests;
                        outCycles  <= cycles;
                        outValid   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= RESULT;
                    end else if (cycles != '1) begin
                        cycles <= cycles + 1'b1;
                    end
                end
                RESULT: begin
                    if (host.out_ready) begin
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                        state    <= LOAD;
                    end
                end
                default: begin
                    state   <= LOAD;
                    inReady <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_search_frontend.sv
// Directed bench for search_frontend; a second instance with a
// 4-bit cycle counter exercises saturation on the same stimulus.
module tb_search_frontend;
    import search_frontend_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [31:0] inData;
    logic        outReady;
    logic        sDone;
    logic [31:0] sResult;
    logic [31:0] sDigests;

    logic         sStartA, sStartB, busyA, busyB;
    logic [4:0]   sTargetA, sTargetB;
    logic [511:0] sMessageA, sMessageB;
    logic [31:0]  sCounterA, sCounterB, sIncrementA, sIncrementB;

    int vectors = 0;
    int miscompares = 0;
    int startPulses = 0;
    int accepts = 0;

    logic [31:0]  frame [FRAME_WORDS];
    logic [511:0] expMsg;

    always #5 clk = ~clk;

    search_frontend_if #(.CYCLE_W(32)) hostA ();
    search_frontend_if #(.CYCLE_W(4))  hostB ();

    assign hostA.in_valid  = inValid;
    assign hostA.in_data   = inData;
    assign hostA.out_ready = outReady;
    assign hostB.in_valid  = inValid;
    assign hostB.in_data   = inData;
    assign hostB.out_ready = outReady;

    search_frontend #(.CYCLE_W(32)) dutA (
        .clk         (clk),
        .reset       (reset),
        .host        (hostA),
        .s_start     (sStartA),
        .s_target    (sTargetA),
        .s_message   (sMessageA),
        .s_counter   (sCounterA),
        .s_increment (sIncrementA),
        .s_done      (sDone),
        .s_result    (sResult),
        .s_digests   (sDigests),
        .busy        (busyA)
    );

    search_frontend #(.CYCLE_W(4)) dutB (
        .clk         (clk),
        .reset       (reset),
        .host        (hostB),
        .s_start     (sStartB),
        .s_target    (sTargetB),
        .s_message   (sMessageB),
        .s_counter   (sCounterB),
        .s_increment (sIncrementB),
        .s_done      (sDone),
        .s_result    (sResult),
        .s_digests   (sDigests),
        .busy        (busyB)
    );

    always @(posedge clk) begin
        if (sStartA) startPulses++;
        if (hostA.in_valid && hostA.in_ready) accepts++;
    end

    task automatic buildFrame(input logic [31:0] hdr, input logic [31:0] ctr,
                              input logic [31:0] inc, input logic [31:0] base);
        frame[0] = hdr;
        frame[1] = ctr;
        frame[2] = inc;
        for (int i = 0; i < MSG_WORDS; i++) frame[MSG_BASE + i] = base + 32'(i + 1);
        expMsg = '0;
        for (int k = MSG_BASE; k < FRAME_WORDS; k++)
            expMsg[(FRAME_WORDS - 1 - k) * 32 +: 32] = frame[k];
    endtask

    task automatic sendWords(input int first, input int last, input bit gap);
        for (int i = first; i <= last; i++) begin
            inValid = 1'b1;
            inData  = frame[i];
            @(negedge clk);
            if (gap && i < FRAME_WORDS - 1) begin
                inValid = 1'b0;
                inData  = 32'hBAD0_0000 + 32'(i);
                @(negedge clk);
            end
        end
        inValid = 1'b0;
    endtask

    task automatic runSearch(input int n, input logic [31:0] res, input logic [31:0] dig);
        repeat (n) @(negedge clk);
        sDone = 1'b1; sResult = res; sDigests = dig;
        @(negedge clk);
        sDone = 1'b0; sResult = '0; sDigests = '0;
    endtask

    task automatic handshake();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (hostA.out_valid !== 1'b0 || sStartA !== 1'b0 || busyA !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: out_valid=%b s_start=%b busy=%b want 0 0 0",
                     hostA.out_valid, sStartA, busyA);
        end
        vectors++;
        if (sTargetA !== 5'd0 || sCounterA !== 32'd0 || sIncrementA !== 32'd0 || sMessageA !== 512'd0) begin
            miscompares++;
            $display("FAIL reset_data: target=%h counter=%h inc=%h want zeros", sTargetA, sCounterA, sIncrementA);
        end
        vectors++;
        if (hostA.out_result !== 32'd0 || hostA.out_digests !== 32'd0 || hostA.out_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_out: result=%h digests=%h cycles=%h want zeros",
                     hostA.out_result, hostA.out_digests, hostA.out_cycles);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (hostA.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", hostA.in_ready);
        end
    endtask

    task automatic test_basic_frame();
        int p0;
        p0 = startPulses;
        buildFrame(32'h0000_0003, 32'h0000_0010, 32'h0000_0001, 32'h0);
        sendWords(0, FRAME_WORDS - 1, 1'b0);
        vectors++;
        if (sStartA !== 1'b1 || busyA !== 1'b1 || hostA.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_start: s_start=%b busy=%b in_ready=%b want 1 1 0",
                     sStartA, busyA, hostA.in_ready);
        end
        vectors++;
        if (sTargetA !== 5'd3 || sCounterA !== 32'h10 || sIncrementA !== 32'h1) begin
            miscompares++;
            $display("FAIL basic_fields: target=%h counter=%h inc=%h want 03 10 1",
                     sTargetA, sCounterA, sIncrementA);
        end
        vectors++;
        if (sMessageA[511:480] !== 32'h01 || sMessageA[31:0] !== 32'h10 || sMessageA !== expMsg) begin
            miscompares++;
            $display("FAIL basic_message: got %h want %h", sMessageA, expMsg);
        end
        runSearch(39, 32'h15, 32'd6);
        vectors++;
        if (hostA.out_valid !== 1'b1 || hostA.out_result !== 32'h15 || hostA.out_digests !== 32'd6) begin
            miscompares++;
            $display("FAIL basic_result: valid=%b result=%h digests=%0d want 1 15 6",
                     hostA.out_valid, hostA.out_result, hostA.out_digests);
        end
        vectors++;
        if (hostA.out_cycles !== 32'd39 || hostB.out_cycles !== 4'hF) begin
            miscompares++;
            $display("FAIL basic_cycles: got %0d/%h want 39/f", hostA.out_cycles, hostB.out_cycles);
        end
        vectors++;
        if (startPulses - p0 !== 1 || busyA !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pulses: pulses=%0d busy=%b want 1 0", startPulses - p0, busyA);
        end
        handshake();
        vectors++;
        if (hostA.out_valid !== 1'b0 || hostA.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b want 0 1", hostA.out_valid, hostA.in_ready);
        end
    endtask

    task automatic test_gapped_load();
        int a0, p0;
        a0 = accepts;
        p0 = startPulses;
        buildFrame(32'hFFFF_FFF5, 32'hDEAD_BEEF, 32'h1234_5678, 32'hA000_0000);
        sendWords(0, FRAME_WORDS - 2, 1'b1);
        vectors++;
        if (accepts - a0 !== 18 || sStartA !== 1'b0 || startPulses !== p0 || hostA.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_partial: accepts=%0d s_start=%b pulses=%0d want 18 0 0",
                     accepts - a0, sStartA, startPulses - p0);
        end
        sendWords(FRAME_WORDS - 1, FRAME_WORDS - 1, 1'b0);
        vectors++;
        if (accepts - a0 !== 19 || sStartA !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_last: accepts=%0d s_start=%b want 19 1", accepts - a0, sStartA);
        end
        vectors++;
        if (sTargetA !== 5'h15 || sCounterA !== 32'hDEAD_BEEF || sIncrementA !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL gap_fields: target=%h counter=%h inc=%h want 15 deadbeef 12345678",
                     sTargetA, sCounterA, sIncrementA);
        end
        vectors++;
        if (sMessageA !== expMsg) begin
            miscompares++;
            $display("FAIL gap_message: got %h want %h", sMessageA, expMsg);
        end
        runSearch(14, 32'hCAFE_0001, 32'd77);
        vectors++;
        if (hostA.out_cycles !== 32'd14 || hostB.out_cycles !== 4'd14 || hostA.out_result !== 32'hCAFE_0001) begin
            miscompares++;
            $display("FAIL gap_result: cycles=%0d/%0d result=%h want 14/14 cafe0001",
                     hostA.out_cycles, hostB.out_cycles, hostA.out_result);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int a0;
        buildFrame(32'h7, 32'd100, 32'd3, 32'h5000_0000);
        sendWords(0, FRAME_WORDS - 1, 1'b0);
        runSearch(20, 32'h0BAD_F00D, 32'd123);
        a0 = accepts;
        inValid = 1'b1;
        inData  = 32'h1111_2222;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (hostA.out_valid !== 1'b1 || hostA.out_result !== 32'h0BAD_F00D ||
                hostA.out_digests !== 32'd123 || hostA.out_cycles !== 32'd20 || hostA.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_c%0d: valid=%b result=%h digests=%0d cycles=%0d in_ready=%b want 1 0badf00d 123 20 0",
                         c, hostA.out_valid, hostA.out_result, hostA.out_digests, hostA.out_cycles, hostA.in_ready);
            end
        end
        inValid = 1'b0;
        vectors++;
        if (accepts !== a0 || sCounterA !== 32'd100) begin
            miscompares++;
            $display("FAIL hold_accepts: accepts=%0d counter=%0d want 0 100", accepts - a0, sCounterA);
        end
        handshake();
        vectors++;
        if (hostA.out_valid !== 1'b0 || hostA.in_ready !== 1'b1 || hostA.out_result !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL hold_release: valid=%b in_ready=%b result=%h want 0 1 0badf00d",
                     hostA.out_valid, hostA.in_ready, hostA.out_result);
        end
    endtask

    task automatic test_spurious_done();
        int p0;
        p0 = startPulses;
        buildFrame(32'h1, 32'd200, 32'd2, 32'h7000_0000);
        sendWords(0, 4, 1'b0);
        sDone = 1'b1; sResult = 32'hFFFF_FFFF; sDigests = 32'hFFFF;
        @(negedge clk);
        sDone = 1'b0; sResult = '0; sDigests = '0;
        vectors++;
        if (hostA.out_valid !== 1'b0 || busyA !== 1'b0 || hostA.in_ready !== 1'b1 ||
            hostA.out_result !== 32'h0BAD_F00D || startPulses !== p0) begin
            miscompares++;
            $display("FAIL spur_load: valid=%b busy=%b in_ready=%b result=%h want 0 0 1 0badf00d",
                     hostA.out_valid, busyA, hostA.in_ready, hostA.out_result);
        end
        sendWords(5, FRAME_WORDS - 1, 1'b0);
        vectors++;
        if (sStartA !== 1'b1 || sMessageA !== expMsg || sCounterA !== 32'd200) begin
            miscompares++;
            $display("FAIL spur_frame: s_start=%b counter=%0d message=%h want 1 200 %h",
                     sStartA, sCounterA, sMessageA, expMsg);
        end
        runSearch(3, 32'h11, 32'h22);
        sDone = 1'b1; sResult = 32'h99; sDigests = 32'h98;
        @(negedge clk);
        sDone = 1'b0; sResult = '0; sDigests = '0;
        vectors++;
        if (hostA.out_valid !== 1'b1 || hostA.out_result !== 32'h11 ||
            hostA.out_digests !== 32'h22 || hostA.out_cycles !== 32'd3) begin
            miscompares++;
            $display("FAIL spur_result: valid=%b result=%h digests=%h cycles=%0d want 1 11 22 3",
                     hostA.out_valid, hostA.out_result, hostA.out_digests, hostA.out_cycles);
        end
        handshake();
    endtask

    task automatic test_reset_mid_frame();
        buildFrame(32'h9, 32'h333, 32'h444, 32'h8000_0000);
        sendWords(0, 6, 1'b0);
        reset = 1'b1;
        #1;
        vectors++;
        if (sTargetA !== 5'd0 || sCounterA !== 32'd0 || sMessageA !== 512'd0 ||
            hostA.out_result !== 32'd0 || hostA.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid: target=%h counter=%h result=%h in_ready=%b want 0 0 0 1",
                     sTargetA, sCounterA, hostA.out_result, hostA.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        buildFrame(32'h2, 32'h555, 32'h666, 32'h9000_0000);
        sendWords(0, FRAME_WORDS - 1, 1'b0);
        vectors++;
        if (sStartA !== 1'b1 || sTargetA !== 5'd2 || sCounterA !== 32'h555 || sIncrementA !== 32'h666) begin
            miscompares++;
            $display("FAIL rst_fresh: s_start=%b target=%h counter=%h inc=%h want 1 2 555 666",
                     sStartA, sTargetA, sCounterA, sIncrementA);
        end
        vectors++;
        if (sMessageA !== expMsg) begin
            miscompares++;
            $display("FAIL rst_message: got %h want %h", sMessageA, expMsg);
        end
        runSearch(2, 32'h1, 32'h1);
        handshake();
    endtask

    task automatic test_saturation();
        buildFrame(32'h1F, 32'h1, 32'h2, 32'hC000_0000);
        sendWords(0, FRAME_WORDS - 1, 1'b0);
        runSearch(30, 32'h42, 32'h43);
        vectors++;
        if (hostA.out_cycles !== 32'd30 || hostB.out_cycles !== 4'hF) begin
            miscompares++;
            $display("FAIL sat_30: got %0d/%h want 30/f", hostA.out_cycles, hostB.out_cycles);
        end
        handshake();
        sendWords(0, FRAME_WORDS - 1, 1'b0);
        runSearch(15, 32'h44, 32'h45);
        vectors++;
        if (hostA.out_cycles !== 32'd15 || hostB.out_cycles !== 4'hF || hostB.out_result !== 32'h44) begin
            miscompares++;
            $display("FAIL sat_15: got %0d/%h result=%h want 15/f 44",
                     hostA.out_cycles, hostB.out_cycles, hostB.out_result);
        end
        handshake();
    endtask

    initial begin
        reset    = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        sDone    = 1'b0;
        sResult  = '0;
        sDigests = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic_frame();
        test_gapped_load();
        test_backpressure();
        test_spurious_done();
        test_reset_mid_frame();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
